// File: rtl/uart_rx_word_fifo.sv
// uart_rx_word_fifo: packs UART bytes little-endian into 32-bit words and
// buffers them in a first-word-fall-through FIFO with a valid/ready output.
// Ports: clk, rst (sync, active-high); rx_data/rx_valid/rx_ferr byte input;
//   word/word_valid/word_ready output handshake; level = words held;
//   overflow/ferr_sticky sticky flags cleared by err_clr.
// Params: DEPTH (power of two, >= 2), TIMEOUT_CYCLES (0 disables timeout).
// Macro UART_RX_FERR_DROP_EN: drop errored bytes and the partial word.
module uart_rx_word_fifo #(
   parameter int DEPTH          = 16,
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [7:0]               rx_data,
   input  logic                     rx_valid,
   input  logic                     rx_ferr,
   output logic [31:0]              word,
   output logic                     word_valid,
   input  logic                     word_ready,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow,
   output logic                     ferr_sticky,
   input  logic                     err_clr
);

   localparam int AW = $clog2(DEPTH);
   localparam int IW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [IW-1:0] IDLE_MAX =
      IW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
   localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

   logic [1:0]    r_byte_cnt;
   logic [23:0]   r_partial;
   logic [IW-1:0] r_idle;
   logic [31:0]   r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_level;
   logic          r_overflow;
   logic          r_ferr;

   logic          w_timeout;
   logic          w_store;
   logic [1:0]    w_cnt_base;
   logic          w_complete;
   logic [31:0]   w_word_in;
   logic          w_pop;
   logic          w_full;
   logic          w_push;
   logic          w_ovf_set;
   logic          w_ferr_set;

   // A byte on the timeout edge starts a fresh word at slot 0.
   assign w_timeout  = (TIMEOUT_CYCLES != 0) && (r_byte_cnt != 2'd0)
                       && (r_idle == IDLE_MAX);
`ifdef UART_RX_FERR_DROP_EN
   assign w_store    = rx_valid && !rx_ferr;
`else
   assign w_store    = rx_valid;
`endif
   assign w_cnt_base = w_timeout ? 2'd0 : r_byte_cnt;
   assign w_complete = w_store && (w_cnt_base == 2'd3);
   assign w_word_in  = {rx_data, r_partial};
   assign w_pop      = (r_level != '0) && word_ready;
   assign w_full     = (r_level == LVL_FULL);
   // A full FIFO still takes the word when the head leaves on the same edge.
   assign w_push     = w_complete && (!w_full || w_pop);
   assign w_ovf_set  = w_complete && w_full && !w_pop;
   assign w_ferr_set = rx_valid && rx_ferr;

   assign word        = r_mem[r_rd_ptr];
   assign word_valid  = (r_level != '0);
   assign level       = r_level;
   assign overflow    = r_overflow;
   assign ferr_sticky = r_ferr;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_byte_cnt <= 2'd0;
         r_partial  <= 24'd0;
         r_idle     <= '0;
      end else begin
         if (rx_valid)
            r_idle <= '0;
         else if (r_byte_cnt != 2'd0 && !w_timeout)
            r_idle <= r_idle + IW'(1);
         else
            r_idle <= '0;

         if (w_store) begin
            r_byte_cnt <= w_cnt_base + 2'd1;
            unique case (w_cnt_base)
               2'd0:    r_partial[7:0]   <= rx_data;
               2'd1:    r_partial[15:8]  <= rx_data;
               2'd2:    r_partial[23:16] <= rx_data;
               default: r_partial        <= r_partial;
            endcase
         end else if (rx_valid || w_timeout) begin
            // Errored byte in drop mode, or timeout: discard partial word.
            r_byte_cnt <= 2'd0;
         end
      end
   end

   // Storage has no reset; only the pointers are cleared.
   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[r_wr_ptr] <= w_word_in;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push)
            r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + AW'(1);
         unique case ({w_push, w_pop})
            2'b10:   r_level <= r_level + (AW+1)'(1);
            2'b01:   r_level <= r_level - (AW+1)'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   // Set has priority over a simultaneous clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_overflow <= 1'b0;
         r_ferr     <= 1'b0;
      end else begin
         r_overflow <= w_ovf_set  | (r_overflow & ~err_clr);
         r_ferr     <= w_ferr_set | (r_ferr & ~err_clr);
      end
   end

endmodule

// File: tb/tb_uart_rx_word_fifo.sv
// tb_uart_rx_word_fifo: randomized self-checking bench for uart_rx_word_fifo
// against a byte-queue / word-queue reference model.
module tb_uart_rx_word_fifo;

   localparam int DEPTH = 16;
   localparam int TO    = 12;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  rx_data = 8'd0;
   logic        rx_valid = 1'b0;
   logic        rx_ferr = 1'b0;
   logic [31:0] word;
   logic        word_valid;
   logic        word_ready = 1'b0;
   logic [4:0]  level;
   logic        overflow;
   logic        ferr_sticky;
   logic        err_clr = 1'b0;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0]  m_part[$];
   logic [31:0] m_fifo[$];
   int          m_since = 0;
   bit          m_ovf = 0;
   bit          m_ferr = 0;

   uart_rx_word_fifo #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ferr(rx_ferr),
      .word(word), .word_valid(word_valid), .word_ready(word_ready),
      .level(level), .overflow(overflow), .ferr_sticky(ferr_sticky),
      .err_clr(err_clr)
   );

   always #5 clk = ~clk;

   // One clock: drive inputs, advance the model, then step past the edge.
   task automatic cycle(input bit v, input logic [7:0] d, input bit fe,
                        input bit rdy, input bit clr);
      bit pop, push_req, ovf_set;
      logic [31:0] w;
      rx_valid = v; rx_data = d; rx_ferr = fe;
      word_ready = rdy; err_clr = clr;
      pop = (m_fifo.size() > 0) && rdy;
      push_req = 0; ovf_set = 0; w = '0;
      if (m_part.size() > 0 && m_since + 1 == TO) m_part.delete();
      if (v) begin
         m_since = 0;
`ifdef UART_RX_FERR_DROP_EN
         if (fe) m_part.delete();
         else m_part.push_back(d);
`else
         m_part.push_back(d);
`endif
         if (m_part.size() == 4) begin
            w = {m_part[3], m_part[2], m_part[1], m_part[0]};
            m_part.delete();
            push_req = 1;
         end
      end else begin
         m_since++;
      end
      if (pop) void'(m_fifo.pop_front());
      if (push_req) begin
         if (m_fifo.size() < DEPTH) m_fifo.push_back(w);
         else ovf_set = 1;
      end
      m_ovf  = ovf_set | (m_ovf & !clr);
      m_ferr = (v & fe) | (m_ferr & !clr);
      @(posedge clk); #1;
      rx_valid = 0; rx_ferr = 0; word_ready = 0; err_clr = 0;
   endtask

   task automatic idle(input int n);
      repeat (n) cycle(0, 8'h00, 0, 0, 0);
   endtask

   task automatic send_word(input logic [31:0] w, input bit rdy_last,
                            input bit clr_last);
      cycle(1, w[7:0], 0, 0, 0);
      cycle(1, w[15:8], 0, 0, 0);
      cycle(1, w[23:16], 0, 0, 0);
      cycle(1, w[31:24], 0, rdy_last, clr_last);
   endtask

   task automatic do_reset();
      rst = 1;
      @(posedge clk); #1;
      rst = 0;
      m_part.delete(); m_fifo.delete();
      m_since = 0; m_ovf = 0; m_ferr = 0;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks += 4;
      if (word_valid !== 1'b0) begin
         n_errors++; $display("FAIL reset_valid got %b exp 0", word_valid);
      end
      if (level !== 5'd0) begin
         n_errors++; $display("FAIL reset_level got %0d exp 0", level);
      end
      if (overflow !== 1'b0) begin
         n_errors++; $display("FAIL reset_ovf got %b exp 0", overflow);
      end
      if (ferr_sticky !== 1'b0) begin
         n_errors++; $display("FAIL reset_ferr got %b exp 0", ferr_sticky);
      end
   endtask

   task automatic test_basic();
      do_reset();
      cycle(1, 8'h78, 0, 0, 0);
      cycle(1, 8'h56, 0, 0, 0);
      cycle(1, 8'h34, 0, 0, 0);
      n_checks++;
      if (word_valid !== 1'b0) begin
         n_errors++; $display("FAIL basic_early got %b exp 0", word_valid);
      end
      cycle(1, 8'h12, 0, 0, 0);
      n_checks += 3;
      if (word_valid !== 1'b1) begin
         n_errors++; $display("FAIL basic_valid got %b exp 1", word_valid);
      end
      if (word !== 32'h12345678) begin
         n_errors++; $display("FAIL basic_word got %h exp 12345678", word);
      end
      if (level !== 5'd1) begin
         n_errors++; $display("FAIL basic_level got %0d exp 1", level);
      end
      cycle(0, 8'h00, 0, 1, 0);
      n_checks += 2;
      if (level !== 5'd0) begin
         n_errors++; $display("FAIL basic_pop_lvl got %0d exp 0", level);
      end
      if (word_valid !== 1'b0) begin
         n_errors++; $display("FAIL basic_pop_vld got %b exp 0", word_valid);
      end
   endtask

   task automatic test_full_overflow();
      logic [31:0] ws[$];
      logic [31:0] w_new, w_last;
      do_reset();
      for (int i = 0; i < DEPTH; i++) begin
         ws.push_back($urandom);
         send_word(ws[i], 0, 0);
      end
      n_checks += 2;
      if (level !== 5'd16) begin
         n_errors++; $display("FAIL full_level got %0d exp 16", level);
      end
      if (overflow !== 1'b0) begin
         n_errors++; $display("FAIL full_noovf got %b exp 0", overflow);
      end
      send_word($urandom, 0, 0);
      n_checks += 3;
      if (overflow !== 1'b1) begin
         n_errors++; $display("FAIL ovf_flag got %b exp 1", overflow);
      end
      if (level !== 5'd16) begin
         n_errors++; $display("FAIL ovf_level got %0d exp 16", level);
      end
      if (word !== ws[0]) begin
         n_errors++; $display("FAIL ovf_head got %h exp %h", word, ws[0]);
      end
      send_word($urandom, 0, 1);
      n_checks++;
      if (overflow !== 1'b1) begin
         n_errors++; $display("FAIL ovf_setwins got %b exp 1", overflow);
      end
      cycle(0, 8'h00, 0, 0, 1);
      n_checks++;
      if (overflow !== 1'b0) begin
         n_errors++; $display("FAIL ovf_clr got %b exp 0", overflow);
      end
      w_new = $urandom;
      send_word(w_new, 1, 0);
      n_checks += 3;
      if (level !== 5'd16) begin
         n_errors++; $display("FAIL pushpop_lvl got %0d exp 16", level);
      end
      if (overflow !== 1'b0) begin
         n_errors++; $display("FAIL pushpop_ovf got %b exp 0", overflow);
      end
      if (word !== ws[1]) begin
         n_errors++; $display("FAIL pushpop_head got %h exp %h", word, ws[1]);
      end
      w_last = '0;
      for (int i = 0; i < DEPTH; i++) begin
         n_checks++;
         if (m_fifo.size() == 0 || word !== m_fifo[0]) begin
            n_errors++;
            $display("FAIL drain_%0d got %h exp %h", i, word,
                     m_fifo.size() ? m_fifo[0] : 32'h0);
         end
         w_last = word;
         cycle(0, 8'h00, 0, 1, 0);
      end
      n_checks += 2;
      if (w_last !== w_new) begin
         n_errors++; $display("FAIL drain_last got %h exp %h", w_last, w_new);
      end
      if (word_valid !== 1'b0) begin
         n_errors++; $display("FAIL drain_empty got %b exp 0", word_valid);
      end
   endtask

   task automatic test_timeout();
      do_reset();
      cycle(1, 8'h01, 0, 0, 0);
      cycle(1, 8'h02, 0, 0, 0);
      idle(TO);
      cycle(1, 8'hAA, 0, 0, 0);
      cycle(1, 8'hBB, 0, 0, 0);
      cycle(1, 8'hCC, 0, 0, 0);
      cycle(1, 8'hDD, 0, 0, 0);
      n_checks += 3;
      if (level !== 5'd1) begin
         n_errors++; $display("FAIL to_level got %0d exp 1", level);
      end
      if (word !== 32'hDDCCBBAA) begin
         n_errors++; $display("FAIL to_word got %h exp ddccbbaa", word);
      end
      if (overflow !== 1'b0) begin
         n_errors++; $display("FAIL to_ovf got %b exp 0", overflow);
      end
      cycle(0, 8'h00, 0, 1, 0);
      cycle(1, 8'h10, 0, 0, 0);
      idle(TO - 2);
      cycle(1, 8'h20, 0, 0, 0);
      idle(TO - 1);
      cycle(1, 8'h30, 0, 0, 0);
      cycle(1, 8'h31, 0, 0, 0);
      cycle(1, 8'h32, 0, 0, 0);
      n_checks++;
      if (level !== 5'd0) begin
         n_errors++; $display("FAIL to_edge_early got %0d exp 0", level);
      end
      cycle(1, 8'h33, 0, 0, 0);
      n_checks += 2;
      if (level !== 5'd1) begin
         n_errors++; $display("FAIL to_edge_lvl got %0d exp 1", level);
      end
      if (word !== 32'h33323130) begin
         n_errors++; $display("FAIL to_edge_word got %h exp 33323130", word);
      end
   endtask

   task automatic test_ferr();
      do_reset();
      cycle(1, 8'h11, 0, 0, 0);
      cycle(1, 8'h22, 1, 0, 0);
      cycle(1, 8'h33, 0, 0, 0);
      cycle(1, 8'h44, 0, 0, 0);
      cycle(1, 8'h55, 0, 0, 0);
      cycle(1, 8'h66, 0, 0, 0);
      n_checks += 3;
      if (ferr_sticky !== 1'b1) begin
         n_errors++; $display("FAIL ferr_flag got %b exp 1", ferr_sticky);
      end
      if (level !== 5'd1) begin
         n_errors++; $display("FAIL ferr_level got %0d exp 1", level);
      end
`ifdef UART_RX_FERR_DROP_EN
      if (word !== 32'h66554433) begin
         n_errors++; $display("FAIL ferr_word got %h exp 66554433", word);
      end
`else
      if (word !== 32'h44332211) begin
         n_errors++; $display("FAIL ferr_word got %h exp 44332211", word);
      end
      cycle(1, 8'h77, 0, 1, 0);
      cycle(1, 8'h88, 0, 0, 0);
      n_checks += 2;
      if (level !== 5'd1) begin
         n_errors++; $display("FAIL ferr_part_lvl got %0d exp 1", level);
      end
      if (word !== 32'h88776655) begin
         n_errors++; $display("FAIL ferr_part got %h exp 88776655", word);
      end
`endif
      cycle(1, 8'h99, 1, 0, 1);
      n_checks++;
      if (ferr_sticky !== 1'b1) begin
         n_errors++; $display("FAIL ferr_setwins got %b exp 1", ferr_sticky);
      end
      cycle(0, 8'h00, 0, 0, 1);
      n_checks++;
      if (ferr_sticky !== 1'b0) begin
         n_errors++; $display("FAIL ferr_clr got %b exp 0", ferr_sticky);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      cycle(1, 8'h01, 0, 0, 0);
      cycle(1, 8'h02, 1, 0, 0);
      cycle(1, 8'h03, 0, 0, 0);
      do_reset();
      n_checks += 3;
      if (ferr_sticky !== 1'b0 || overflow !== 1'b0) begin
         n_errors++;
         $display("FAIL rmid_flags got %b%b exp 00", ferr_sticky, overflow);
      end
      if (level !== 5'd0) begin
         n_errors++; $display("FAIL rmid_level got %0d exp 0", level);
      end
      if (word_valid !== 1'b0) begin
         n_errors++; $display("FAIL rmid_valid got %b exp 0", word_valid);
      end
      send_word(32'h0A0B0C0D, 0, 0);
      n_checks += 2;
      if (level !== 5'd1) begin
         n_errors++; $display("FAIL rmid_wlvl got %0d exp 1", level);
      end
      if (word !== 32'h0A0B0C0D) begin
         n_errors++; $display("FAIL rmid_word got %h exp 0a0b0c0d", word);
      end
   endtask

   task automatic test_wraparound();
      logic [31:0] sent[$];
      logic [31:0] got[$];
      logic [31:0] w;
      bit rdy;
      int guard;
      do_reset();
      for (int i = 0; i < 40; i++) begin
         w = $urandom;
         sent.push_back(w);
         for (int b = 0; b < 4; b++) begin
            repeat ($urandom_range(0, 2)) begin
               rdy = ($urandom_range(0, 3) != 0);
               if (word_valid && rdy) got.push_back(word);
               cycle(0, 8'h00, 0, rdy, 0);
            end
            rdy = ($urandom_range(0, 3) != 0);
            n_checks += 2;
            if (level > 5'd16 || level !== 5'(m_fifo.size())) begin
               n_errors++;
               $display("FAIL wrap_level got %0d exp %0d", level, m_fifo.size());
            end
            if (m_fifo.size() > 0 && word !== m_fifo[0]) begin
               n_errors++;
               $display("FAIL wrap_head got %h exp %h", word, m_fifo[0]);
            end
            if (word_valid && rdy) got.push_back(word);
            cycle(1, w[8*b +: 8], 0, rdy, 0);
         end
      end
      guard = 0;
      while (word_valid && guard < 100) begin
         got.push_back(word);
         cycle(0, 8'h00, 0, 1, 0);
         guard++;
      end
      n_checks += 3;
      if (word_valid !== 1'b0) begin
         n_errors++; $display("FAIL wrap_drain got %b exp 0", word_valid);
      end
      if (got.size() != 40 || overflow !== 1'b0) begin
         n_errors++;
         $display("FAIL wrap_count got %0d exp 40", got.size());
      end
      if (got != sent) begin
         n_errors++; $display("FAIL wrap_order got mismatched sequence exp input order");
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_full_overflow();
      test_timeout();
      test_ferr();
      test_reset_mid();
      test_wraparound();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/uart_rx_word_fifo.md
# uart_rx_word_fifo

- Sits directly downstream of the UART receiver and consumes its byte strobe and framing-error flag.
- Packs received bytes little-endian into 32-bit words and buffers them in a first-word-fall-through FIFO.
- Presents the words to the core/program loader over a valid/ready handshake.
- Discards stale partial words on inter-byte timeout and reports overflow and framing errors as sticky flags.

## Interface
Parameters:
- DEPTH, 16, FIFO depth in words; power of two, ≥ 2.
- TIMEOUT_CYCLES, 1_000_000, idle clocks after which a partial word is discarded; 0 disables the timeout.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- rx_data  in  8  received byte; valid only when rx_valid=1.
- rx_valid  in  1  single-cycle byte strobe from the receiver.
- rx_ferr  in  1  framing error for the current byte; qualified by rx_valid.
- word  out  32  FIFO head word; don't-care while word_valid=0.
- word_valid  out  1  FIFO non-empty.
- word_ready  in  1  consumer accepts the head word.
- level  out  $clog2(DEPTH)+1  number of words held, 0..DEPTH.
- overflow  out  1  sticky; a completed word was dropped because the FIFO was full.
- ferr_sticky  out  1  sticky; at least one byte arrived with rx_ferr=1.
- err_clr  in  1  one-cycle pulse that clears overflow and ferr_sticky.

## Operation
- **Assembler state:** byte_cnt (0..3), 24-bit partial register, idle counter.
- **Byte accepted** (rx_valid=1 at an edge):
  - byte n goes to bits [8n+7:8n].
  - byte_cnt increments; the idle counter clears.
- **Word completion:** on the 4th byte, {rx_data, partial[23:0]} is offered to the FIFO and byte_cnt wraps to 0.
- **Push rule:**
  - Accepted if level<DEPTH, or if level==DEPTH and a pop occurs on the same edge.
  - Otherwise the word is dropped, overflow←1, and the FIFO contents are unchanged.
- **Pop:** word_valid && word_ready. The head advances and level decrements.
  - Push and pop on the same edge leave level unchanged.
- **Pointers:** wrap modulo DEPTH. Full/empty are derived from level.
- **Timeout:**
  - While byte_cnt≠0 and no byte arrives, the idle counter increments each clock.
  - When it reaches TIMEOUT_CYCLES−1, byte_cnt←0 and the partial data is discarded. Nothing is pushed and no flag is set.
  - The idle counter holds at 0 while byte_cnt=0.
- **Sticky flags:**
  - Set by their events; cleared only by err_clr or rst.
  - If set and err_clr occur on the same edge, set wins.
- **Reset:** byte_cnt=0, FIFO empty, word_valid=0, level=0, overflow=0, ferr_sticky=0, idle counter=0.
  - Reset in the middle of a word discards the partial word.
  - Reset does not clear the memory array; only the pointers are reset.

## Timing
- **Latency:** 4th byte strobe at edge k → word_valid=1 and word correct in the cycle after edge k (FIFO previously empty). Minimum latency is 1 clock.
- **Throughput:** one byte per clock is sustained; rx_valid may be high on consecutive cycles.
- **Output paths:** word_valid, level, overflow and ferr_sticky are registered, with no combinational path from rx_* inputs.
  - word is read combinationally from the memory at the read pointer (FWFT).
- **Handshake:**
  - word may change only after a pop or when the FIFO goes from empty to non-empty.
  - Once word_valid=1, it stays high until the pop of the last entry.
- **Flag timing:** overflow and ferr_sticky rise on the edge of the triggering byte strobe.
- **Timeout boundary:** the discard edge is exactly TIMEOUT_CYCLES clocks after the last accepted byte. A byte arriving on that same edge is kept as byte 0 of a new word.

## Configuration
- **Macro:** UART_RX_FERR_DROP_EN.
- **Defined:**
  - A byte with rx_ferr=1 is not stored.
  - byte_cnt←0, discarding any partial word; ferr_sticky←1.
- **Undefined:**
  - A byte with rx_ferr=1 is assembled like any other byte.
  - ferr_sticky←1.
- **Either way:** the idle counter clears on the errored byte.

## Test plan
- **Basic assembly:** bytes 0x78,0x56,0x34,0x12 back-to-back → one cycle after the 4th strobe, word_valid=1, word=0x12345678, level=1. With word_ready=1 for one cycle → level=0, word_valid=0.
- **Full and overflow:**
  - DEPTH=16, word_ready=0, push 16 words → level=16.
  - 17th word → overflow=1, level=16, the head is still word 0.
  - Next word completing on the same cycle as a pop → accepted, level=16, the last entry equals the new word.
- **Timeout:** bytes 0x01,0x02, then idle TIMEOUT_CYCLES clocks, then 0xAA,0xBB,0xCC,0xDD → exactly one word, 0xDDCCBBAA; overflow=0.
- **Framing error:** bytes 0x11,0x22(ferr),0x33,0x44,0x55,0x66.
  - With UART_RX_FERR_DROP_EN → one word, 0x66554433.
  - Without → word 0x44332211 followed by a partial word with byte_cnt=2.
  - ferr_sticky=1 in both cases; an err_clr pulse → ferr_sticky=0.
- **Reset mid-operation:** 3 bytes, then rst for 1 cycle, then 0x0D,0x0C,0x0B,0x0A → exactly one word, 0x0A0B0C0D; all flags 0 after reset.
- **Wrap-around:** 40 words pushed and popped with random word_ready → output sequence matches input order; level never exceeds 16.
